// File: rtl/reaction_round_scheduler_if.sv
// Signal bundle between the reaction-timer session controller and its
// surroundings: debounced buttons, ms tick, RNG value, LED and result fields.
interface reaction_round_scheduler_if #(
  parameter int unsigned MS_W    = 13,
  parameter int unsigned DELAY_W = 14
);

  // Stimulus side: buttons, timebase and random delay
  logic               tick_1ms;
  logic               start_btn;
  logic               react_btn;
  logic [DELAY_W-1:0] rand_delay;

  // Controller side: LED, session status and results
  logic               rng_enable;
  logic               led_on;
  logic               busy;
  logic               false_start;
  logic [3:0]         round_idx;
  logic               result_valid;
  logic [MS_W-1:0]    result_ms;
  logic [MS_W-1:0]    best_ms;
  logic [MS_W-1:0]    avg_ms;
  logic               done;

  // Drives buttons/tick/RNG and observes the session results
  modport master (
    output tick_1ms, start_btn, react_btn, rand_delay,
    input  rng_enable, led_on, busy, false_start, round_idx,
           result_valid, result_ms, best_ms, avg_ms, done
  );

  // The session controller itself
  modport slave (
    input  tick_1ms, start_btn, react_btn, rand_delay,
    output rng_enable, led_on, busy, false_start, round_idx,
           result_valid, result_ms, best_ms, avg_ms, done
  );

endinterface

// File: rtl/reaction_round_scheduler.sv
// Multi-round reaction-timer session controller. Arms a random wait, lights
// the LED, measures reaction time in ms, handles false starts and timeouts,
// and keeps best and average results over ROUNDS trials.
module reaction_round_scheduler #(
  parameter int unsigned ROUNDS       = 4,
  parameter int unsigned MS_W         = 13,
  parameter int unsigned DELAY_W      = 14,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned TIMEOUT_MS   = 2000,
  parameter int unsigned GAP_MS       = 500,
  parameter int unsigned FAULT_MS     = 1000
) (
  input  logic                        clk,
  input  logic                        ck_reset,
  reaction_round_scheduler_if.slave   bus
);

  localparam int unsigned LOG_R = $clog2(ROUNDS);
  localparam int unsigned SUM_W = MS_W + LOG_R;
  localparam int unsigned TGT_W = DELAY_W + 1;
  // Counter must reach the largest of the wait target and the ms windows
  localparam int unsigned CNT_W = ((TGT_W > MS_W) ? TGT_W : MS_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    GO,
    REC,
    GAP,
    FAULT,
    DONE
  } stateT;

  stateT             state;
  logic [CNT_W-1:0]  msCnt;
  logic [TGT_W-1:0]  target;
  logic [SUM_W-1:0]  sum;
  logic              startPrev;
  logic              reactPrev;

  logic              startEdge;
  logic              reactEdge;
  logic [CNT_W-1:0]  msNext;
  logic [SUM_W-1:0]  sumNext;
  logic [MS_W-1:0]   bestNext;
  logic              lastRound;

  // Rising-edge detection and running arithmetic shared by the FSM
  assign startEdge = bus.start_btn & ~startPrev;
  assign reactEdge = bus.react_btn & ~reactPrev;
  assign msNext    = msCnt + CNT_W'(1);
  assign sumNext   = sum + SUM_W'(bus.result_ms);
  assign bestNext  = (bus.result_ms < bus.best_ms) ? bus.result_ms : bus.best_ms;
  assign lastRound = (bus.round_idx == 4'(ROUNDS - 1));

  // Session FSM; every output is registered and updated on the transition
  always_ff @(posedge clk or negedge ck_reset) begin
    if (!ck_reset) begin
      state            <= IDLE;
      msCnt            <= '0;
      target           <= '0;
      sum              <= '0;
      startPrev        <= 1'b0;
      reactPrev        <= 1'b0;
      bus.rng_enable   <= 1'b0;
      bus.led_on       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.false_start  <= 1'b0;
      bus.round_idx    <= '0;
      bus.result_valid <= 1'b0;
      bus.result_ms    <= '0;
      bus.best_ms      <= '1;
      bus.avg_ms       <= '0;
      bus.done         <= 1'b0;
    end else begin
      startPrev        <= bus.start_btn;
      reactPrev        <= bus.react_btn;
      bus.result_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          // RNG free-runs only while idle, not while showing final results
          bus.rng_enable <= (state == IDLE);
          if (startEdge) begin
            state          <= ARM;
            msCnt          <= '0;
            sum            <= '0;
            bus.round_idx  <= '0;
            bus.best_ms    <= '1;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.rng_enable <= 1'b0;
          end
        end

        ARM: begin
          target <= TGT_W'(MIN_DELAY_MS) + TGT_W'(bus.rand_delay);
          msCnt  <= '0;
          state  <= WAIT;
        end

        WAIT: begin
          // A press before the LED wins even against the final tick
          if (reactEdge) begin
            state           <= FAULT;
            msCnt           <= '0;
            bus.false_start <= 1'b1;
            bus.rng_enable  <= 1'b1;
          end else if (bus.tick_1ms) begin
            if (msNext >= CNT_W'(target)) begin
              state      <= GO;
              msCnt      <= '0;
              bus.led_on <= 1'b1;
            end else begin
              msCnt <= msNext;
            end
          end
        end

        GO: begin
          // A press beats both a coincident tick and the timeout
          if (reactEdge) begin
            state            <= REC;
            msCnt            <= '0;
            bus.led_on       <= 1'b0;
            bus.result_ms    <= MS_W'(msCnt);
            bus.result_valid <= 1'b1;
          end else if (bus.tick_1ms) begin
            if (msNext == CNT_W'(TIMEOUT_MS)) begin
              state            <= REC;
              msCnt            <= '0;
              bus.led_on       <= 1'b0;
              bus.result_ms    <= MS_W'(TIMEOUT_MS);
              bus.result_valid <= 1'b1;
            end else begin
              msCnt <= msNext;
            end
          end
        end

        REC: begin
          sum         <= sumNext;
          bus.best_ms <= bestNext;
          msCnt       <= '0;
          if (lastRound) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            bus.avg_ms <= MS_W'(sumNext >> LOG_R);
          end else begin
            state          <= GAP;
            bus.rng_enable <= 1'b1;
          end
        end

        GAP: begin
          if (bus.tick_1ms) begin
            if (msNext >= CNT_W'(GAP_MS)) begin
              state          <= ARM;
              msCnt          <= '0;
              bus.round_idx  <= bus.round_idx + 4'd1;
              bus.rng_enable <= 1'b0;
            end else begin
              msCnt <= msNext;
            end
          end
        end

        FAULT: begin
          // Penalty hold, then retry the same round
          if (bus.tick_1ms) begin
            if (msNext >= CNT_W'(FAULT_MS)) begin
              state           <= ARM;
              msCnt           <= '0;
              bus.false_start <= 1'b0;
              bus.rng_enable  <= 1'b0;
            end else begin
              msCnt <= msNext;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_round_scheduler.sv
// Directed bench for the reaction round scheduler: nominal session, false
// starts, simultaneous events, timeout, DONE restart and mid-session reset.
module tb_reaction_round_scheduler;

  localparam int unsigned MS_W    = 13;
  localparam int unsigned DELAY_W = 14;

  logic clk = 1'b0;
  logic ck_reset;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  reaction_round_scheduler_if #(.MS_W(MS_W), .DELAY_W(DELAY_W)) bus ();

  reaction_round_scheduler #(
    .ROUNDS      (4),
    .MS_W        (MS_W),
    .DELAY_W     (DELAY_W),
    .MIN_DELAY_MS(2),
    .TIMEOUT_MS  (20),
    .GAP_MS      (3),
    .FAULT_MS    (4)
  ) dut (
    .clk     (clk),
    .ck_reset(ck_reset),
    .bus     (bus)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1ms = 1'b1;
      cyc();
      bus.tick_1ms = 1'b0;
    end
  endtask

  task automatic pressReact();
    bus.react_btn = 1'b1;
    cyc();
    bus.react_btn = 1'b0;
  endtask

  task automatic pressStart();
    bus.start_btn = 1'b1;
    cyc();
    bus.start_btn = 1'b0;
    cyc();
  endtask

  task automatic tickAndReact();
    bus.tick_1ms  = 1'b1;
    bus.react_btn = 1'b1;
    cyc();
    bus.tick_1ms  = 1'b0;
    bus.react_btn = 1'b0;
  endtask

  initial begin
    ck_reset       = 1'b0;
    bus.tick_1ms   = 1'b0;
    bus.start_btn  = 1'b0;
    bus.react_btn  = 1'b0;
    bus.rand_delay = 14'd3;
    repeat (3) cyc();

    // Reset values
    chk("rst_led",    32'(bus.led_on), 0);
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_best",   32'(bus.best_ms), 8191);
    chk("rst_result", 32'(bus.result_ms), 0);
    chk("rst_done",   32'(bus.done), 0);
    chk("rst_rng",    32'(bus.rng_enable), 0);

    ck_reset = 1'b1;
    cyc();
    chk("idle_rng", 32'(bus.rng_enable), 1);

    // react ignored in IDLE
    pressReact();
    cyc();
    chk("idle_react_busy",  32'(bus.busy), 0);
    chk("idle_react_valid", 32'(bus.result_valid), 0);

    // Round 0: target 2+3=5, react after 7 ticks
    pressStart();
    chk("s1_busy",  32'(bus.busy), 1);
    chk("s1_round", 32'(bus.round_idx), 0);
    chk("wait_rng", 32'(bus.rng_enable), 0);
    ticks(4);
    chk("r0_led_pre", 32'(bus.led_on), 0);
    ticks(1);
    chk("r0_led_on", 32'(bus.led_on), 1);
    ticks(7);
    pressReact();
    chk("r0_valid",  32'(bus.result_valid), 1);
    chk("r0_result", 32'(bus.result_ms), 7);
    chk("r0_led_off", 32'(bus.led_on), 0);
    cyc();
    chk("r0_valid_pulse", 32'(bus.result_valid), 0);
    chk("r0_best", 32'(bus.best_ms), 7);
    chk("gap_rng", 32'(bus.rng_enable), 1);

    // start ignored during GAP
    pressStart();
    chk("gap_start_busy",  32'(bus.busy), 1);
    chk("gap_start_round", 32'(bus.round_idx), 0);
    ticks(3);
    chk("r1_round", 32'(bus.round_idx), 1);
    cyc();

    // Round 1: false start on tick 3 of 5
    ticks(2);
    tickAndReact();
    chk("fs_flag",  32'(bus.false_start), 1);
    chk("fs_led",   32'(bus.led_on), 0);
    chk("fs_round", 32'(bus.round_idx), 1);
    chk("fs_valid", 32'(bus.result_valid), 0);
    chk("fs_rng",   32'(bus.rng_enable), 1);
    ticks(3);
    chk("fs_hold", 32'(bus.false_start), 1);
    ticks(1);
    chk("fs_release", 32'(bus.false_start), 0);
    chk("fs_round_kept", 32'(bus.round_idx), 1);
    cyc();

    // React edge together with the final WAIT tick -> FAULT
    ticks(4);
    tickAndReact();
    chk("sim_fs_flag", 32'(bus.false_start), 1);
    chk("sim_fs_led",  32'(bus.led_on), 0);
    ticks(4);
    cyc();

    // Round 1 retry: result 3
    ticks(5);
    ticks(3);
    pressReact();
    chk("r1_result", 32'(bus.result_ms), 3);
    chk("r1_valid",  32'(bus.result_valid), 1);
    cyc();
    chk("r1_best", 32'(bus.best_ms), 3);
    ticks(3);
    chk("r2_round", 32'(bus.round_idx), 2);
    cyc();

    // Round 2: react with a coincident tick, result 12
    ticks(5);
    ticks(12);
    tickAndReact();
    chk("r2_result", 32'(bus.result_ms), 12);
    cyc();
    chk("r2_best", 32'(bus.best_ms), 3);
    ticks(3);
    cyc();

    // Round 3: result 2, session ends
    ticks(5);
    ticks(2);
    pressReact();
    chk("r3_result", 32'(bus.result_ms), 2);
    cyc();
    chk("done_flag",  32'(bus.done), 1);
    chk("done_best",  32'(bus.best_ms), 2);
    chk("done_avg",   32'(bus.avg_ms), 6);
    chk("done_round", 32'(bus.round_idx), 3);
    chk("done_busy",  32'(bus.busy), 0);
    chk("done_rng",   32'(bus.rng_enable), 0);

    // react ignored in DONE
    pressReact();
    cyc();
    chk("done_react_valid", 32'(bus.result_valid), 0);
    chk("done_react_done",  32'(bus.done), 1);

    // New session from DONE, target 2+0=2
    bus.rand_delay = 14'd0;
    pressStart();
    chk("s2_done",  32'(bus.done), 0);
    chk("s2_best",  32'(bus.best_ms), 8191);
    chk("s2_round", 32'(bus.round_idx), 0);
    chk("s2_busy",  32'(bus.busy), 1);
    ticks(1);
    chk("s2_led_pre", 32'(bus.led_on), 0);
    ticks(1);
    chk("s2_led_on", 32'(bus.led_on), 1);

    // Timeout after exactly 20 ticks
    ticks(19);
    chk("to_pre_valid", 32'(bus.result_valid), 0);
    chk("to_pre_led",   32'(bus.led_on), 1);
    ticks(1);
    chk("to_valid",  32'(bus.result_valid), 1);
    chk("to_result", 32'(bus.result_ms), 20);
    cyc();
    chk("to_best", 32'(bus.best_ms), 20);
    chk("to_led",  32'(bus.led_on), 0);
    chk("to_busy", 32'(bus.busy), 1);
    ticks(3);
    chk("to_next_round", 32'(bus.round_idx), 1);
    cyc();
    ticks(2);
    chk("mid_led_on", 32'(bus.led_on), 1);
    ticks(4);

    // Asynchronous reset in the middle of GO
    #2 ck_reset = 1'b0;
    #1;
    chk("mid_rst_led",    32'(bus.led_on), 0);
    chk("mid_rst_busy",   32'(bus.busy), 0);
    chk("mid_rst_best",   32'(bus.best_ms), 8191);
    chk("mid_rst_result", 32'(bus.result_ms), 0);
    chk("mid_rst_round",  32'(bus.round_idx), 0);
    chk("mid_rst_avg",    32'(bus.avg_ms), 0);
    cyc();
    ck_reset = 1'b1;
    cyc();
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_rng",  32'(bus.rng_enable), 1);
    pressStart();
    chk("post_rst_start", 32'(bus.busy), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reaction_round_scheduler.md
Name: reaction_round_scheduler

Overview:
Session-level controller for the reaction-timer datapath. Sequences ROUNDS reaction trials: it arms the random-delay generator, times the random wait, lights the test LED, measures reaction time in ms, detects false starts and timeouts, and accumulates best and average results. Sits between the debounced buttons, the LFSR random-delay generator and the 7-segment display driver. It replaces single-shot sequencing with a repeatable multi-round session.

Parameters:
ROUNDS, 4, trials per session; power of two, 2..16
MS_W, 13, width of all ms result fields
DELAY_W, 14, width of rand_delay from the RNG
MIN_DELAY_MS, 1000, fixed floor added to the random delay
TIMEOUT_MS, 2000, max reaction window; must be < 2^MS_W
GAP_MS, 500, idle gap between rounds
FAULT_MS, 1000, penalty hold after a false start

Ports:
clk  in  1  system clock
ck_reset  in  1  asynchronous active-low reset
tick_1ms  in  1  one-clk-wide pulse per millisecond (enable, not a clock)
start_btn  in  1  synchronized/debounced start button, level
react_btn  in  1  synchronized/debounced reaction button, level
rand_delay  in  DELAY_W  current LFSR value
rng_enable  out  1  high while RNG should free-run (IDLE, GAP, FAULT)
led_on  out  1  test LED drive
busy  out  1  session in progress (not IDLE/DONE)
false_start  out  1  high throughout FAULT state
round_idx  out  4  index of current round, 0..ROUNDS-1
result_valid  out  1  1-cycle pulse when a round result is recorded
result_ms  out  MS_W  last recorded reaction time
best_ms  out  MS_W  minimum result this session
avg_ms  out  MS_W  session average, valid when done=1
done  out  1  session complete

Behaviour:
- Reset (async, ck_reset=0): state IDLE; all outputs 0 except best_ms = all-ones; internal sum, ms_cnt, target, and edge-detect registers cleared (edge registers to 0).
- Rising edges of start_btn/react_btn are detected internally (registered previous value); levels are never used directly for decisions.
- ms_cnt counts tick_1ms pulses; it is cleared on every state entry.
- States:
  - IDLE: start edge -> ARM; clear sum, set round_idx=0 and best_ms=all-ones.
  - ARM (1 cycle): latch target = MIN_DELAY_MS + rand_delay (DELAY_W+1 bits, no truncation) -> WAIT.
  - WAIT: react edge -> FAULT. On a tick where ms_cnt+1 >= target -> GO.
  - GO: led_on=1. react edge -> REC with result = ms_cnt. On a tick where ms_cnt+1 == TIMEOUT_MS -> REC with result = TIMEOUT_MS.
  - REC (1 cycle): result_ms updated and result_valid pulsed; sum += result; best_ms = min(best_ms, result). Last round -> DONE, else -> GAP.
  - GAP: after GAP_MS ticks -> ARM; round_idx increments on the transition.
  - FAULT: false_start=1, led_on=0; after FAULT_MS ticks -> ARM. The round is retried; round_idx is unchanged and nothing is accumulated.
  - DONE: done=1; avg_ms = sum >> log2(ROUNDS), registered on entry. Start edge -> ARM as a new session (same clearing as from IDLE).
- Sum width: MS_W + log2(ROUNDS); no overflow possible.
- Same-cycle events:
  - WAIT: react edge together with the final tick -> FAULT (the false start wins).
  - GO: react edge together with a tick -> result = ms_cnt (that tick is not counted); react edge also beats timeout.
- Start edges while busy are ignored. react edges in IDLE, ARM, REC, GAP, FAULT and DONE are ignored.
- Outputs are registered; led_on rises 1 clk after the GO transition decision.
- Reset asserted mid-session aborts immediately to the reset state; no partial results are retained.

Test Plan:
- Reset values: ck_reset low mid-GO -> led_on=0, busy=0, best_ms=8191, result_ms=0, state IDLE on release.
- Nominal round (ROUNDS=4, MIN_DELAY_MS=2, rand_delay=3): start edge -> led_on rises after 5th tick; react edge after 7 further ticks -> result_valid pulse, result_ms=7.
- Full session: results 7, 3, 12, 2 -> done=1, best_ms=2, avg_ms=6 ((24)>>2), round_idx=3.
- False start: react edge on tick 3 of 5 in WAIT -> false_start=1 for FAULT_MS ticks, round_idx unchanged, no result_valid, then re-ARM.
- Timeout (TIMEOUT_MS=20): no react in GO -> result_ms=20 after exactly 20 ticks, session continues.
- Simultaneous react edge and final WAIT tick -> FAULT, led_on never asserts; start edge during GAP ignored; start edge in DONE clears stats and begins round 0.
